// File: rtl/mbgd_phase2_sched_if.sv
// Handshake and data bundle between the MBGD phase-2 sequencer and its surroundings.
// MBGD_P2_GMAX_EN adds the g_absmax status output.
interface mbgd_phase2_sched_if #(
  parameter int DW1      = 8,
  parameter int N        = 8,
  parameter int COL_BITS = 4
);
  logic                start;
  logic                abort;
  logic                busy;
  logic                done;
  logic                col_rd_en;
  logic [COL_BITS-1:0] col_addr;
  logic [DW1*N-1:0]    col_rd_data;
  logic                p2_enable;
  logic [DW1*N-1:0]    p2_x_col;
  logic [DW1-1:0]      p2_g;
  logic                g_wr_en;
  logic [COL_BITS-1:0] g_wr_addr;
  logic [DW1-1:0]      g_wr_data;
`ifdef MBGD_P2_GMAX_EN
  logic [DW1-1:0]      g_absmax;
`endif

  modport master (
    input  start, abort, col_rd_data, p2_g,
    output busy, done, col_rd_en, col_addr, p2_enable, p2_x_col,
           g_wr_en, g_wr_addr, g_wr_data
`ifdef MBGD_P2_GMAX_EN
    , output g_absmax
`endif
  );

  modport slave (
    output start, abort, col_rd_data, p2_g,
    input  busy, done, col_rd_en, col_addr, p2_enable, p2_x_col,
           g_wr_en, g_wr_addr, g_wr_data
`ifdef MBGD_P2_GMAX_EN
    , input g_absmax
`endif
  );
endinterface

// File: rtl/mbgd_phase2_sched.sv
// MBGD phase-2 sequencer: streams columns into the gradient datapath and stores returned bytes.
// Optional MBGD_P2_GMAX_EN tracks the largest |g| written during a pass.
//
//  state | meaning
//  IDLE  | waiting for start
//  RUN   | issuing one column read per cycle
//  DRAIN | waiting for in-flight tags to leave the datapath
//  DONE  | one-cycle completion pulse
module mbgd_phase2_sched #(
  parameter int DW1      = 8,
  parameter int N        = 8,
  parameter int NUM_COLS = 16,
  parameter int COL_BITS = 4,
  parameter int PIPE_LAT = 3
) (
  input  logic                 clk,
  input  logic                 resetn,
  mbgd_phase2_sched_if.master  bus
);

  localparam int TAG_DEPTH = PIPE_LAT + 1;
  localparam logic [COL_BITS-1:0] LAST_COL = COL_BITS'(NUM_COLS - 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

  state_t                              state_q, state_d;
  logic [COL_BITS-1:0]                 cnt_q, cnt_d;
  logic [TAG_DEPTH-1:0]                tag_vld_q, tag_vld_d;
  logic [TAG_DEPTH-1:0][COL_BITS-1:0]  tag_addr_q, tag_addr_d;
  logic                                start_ok;
  logic [DW1*N-1:0]                    x_col;

  assign start_ok = (state_q == S_IDLE) && bus.start && !bus.abort;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    tag_vld_d  = {tag_vld_q[TAG_DEPTH-2:0], 1'b0};
    tag_addr_d = {tag_addr_q[TAG_DEPTH-2:0], {COL_BITS{1'b0}}};

    case (state_q)
      S_IDLE: begin
        if (start_ok) begin
          state_d = S_RUN;
          cnt_d   = '0;
        end
      end
      S_RUN: begin
        tag_vld_d[0]  = 1'b1;
        tag_addr_d[0] = cnt_q;
        cnt_d         = cnt_q + 1'b1;
        if (cnt_q == LAST_COL) begin
          state_d = S_DRAIN;
          cnt_d   = '0;
        end
      end
      S_DRAIN: begin
        // Only the output stage left means the last write is happening now.
        if (!(|tag_vld_q[TAG_DEPTH-2:0])) state_d = S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    if (bus.abort && (state_q != S_IDLE)) begin
      state_d    = S_IDLE;
      cnt_d      = '0;
      tag_vld_d  = '0;
      tag_addr_d = '0;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      tag_vld_q  <= '0;
      tag_addr_q <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      tag_vld_q  <= tag_vld_d;
      tag_addr_q <= tag_addr_d;
    end
  end

  assign x_col         = bus.col_rd_data;
  assign bus.p2_x_col  = x_col;
  assign bus.busy      = (state_q != S_IDLE);
  assign bus.done      = (state_q == S_DONE);
  assign bus.col_rd_en = (state_q == S_RUN);
  assign bus.col_addr  = cnt_q;
  assign bus.p2_enable = (state_q == S_RUN) || (state_q == S_DRAIN);
  assign bus.g_wr_en   = tag_vld_q[TAG_DEPTH-1];
  assign bus.g_wr_addr = tag_addr_q[TAG_DEPTH-1];
  assign bus.g_wr_data = tag_vld_q[TAG_DEPTH-1] ? bus.p2_g : '0;

`ifdef MBGD_P2_GMAX_EN
  logic [DW1-1:0] absmax_q, absmax_d;
  logic [DW1-1:0] g_abs;

  // Most negative code has no positive twin, so it saturates.
  always_comb begin
    g_abs = bus.p2_g;
    if (bus.p2_g[DW1-1]) begin
      if (bus.p2_g == {1'b1, {(DW1-1){1'b0}}}) g_abs = {1'b0, {(DW1-1){1'b1}}};
      else                                     g_abs = -bus.p2_g;
    end
  end

  always_comb begin
    absmax_d = absmax_q;
    if (start_ok)                                       absmax_d = '0;
    else if (tag_vld_q[TAG_DEPTH-1] && (g_abs > absmax_q)) absmax_d = g_abs;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) absmax_q <= '0;
    else         absmax_q <= absmax_d;
  end

  assign bus.g_absmax = absmax_q;
`endif

endmodule

// File: tb/tb_mbgd_phase2_sched.sv
// Table-driven bench for mbgd_phase2_sched with a column memory and 3-stage datapath model.
// Build with MBGD_P2_GMAX_EN defined to also exercise g_absmax.
module tb_mbgd_phase2_sched;
  localparam int DW1 = 8, N = 8, NUM_COLS = 16, COL_BITS = 4, PIPE_LAT = 3;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  always #5 clk = ~clk;

  mbgd_phase2_sched_if #(.DW1(DW1), .N(N), .COL_BITS(COL_BITS)) bus ();

  mbgd_phase2_sched #(
    .DW1(DW1), .N(N), .NUM_COLS(NUM_COLS), .COL_BITS(COL_BITS), .PIPE_LAT(PIPE_LAT)
  ) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus)
  );

  int errors = 0;
  int checks = 0;
  bit gmode  = 1'b0;

  // Datapath gradient for column k: 3k, with three special bytes in gmode.
  function automatic logic [7:0] g_of(input int k);
    if (gmode) begin
      if (k == 3) return 8'h7F;
      if (k == 5) return 8'h80;
      if (k == 7) return 8'hF0;
    end
    return 8'(k * 3);
  endfunction

  logic [7:0] d1, d2;
  always @(posedge clk) begin
    bus.col_rd_data <= bus.col_rd_en ? {N{{4'b0, bus.col_addr}}} : '0;
    d1              <= g_of(int'(bus.p2_x_col[7:0]));
    d2              <= d1;
    bus.p2_g        <= d2;
  end

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  typedef struct {
    string name;
    int    ncyc;
    int    s2;
    int    s3;
    int    ab;
    bit    gt;
    int    n_rd;
    int    n_wr;
    int    n_done;
    int    gmax;
  } scen_t;

  scen_t tbl[8];

  task automatic run_scen(input scen_t s);
    int a_eff, rd, wr, dn;
    bit e_busy, e_rd, e_wr, e_done, e_en;
    a_eff = (s.ab < 0) ? 1000 : s.ab;
    rd = 0; wr = 0; dn = 0;
    gmode = s.gt;
    for (int c = 0; c < s.ncyc; c++) begin
      bus.start = (c == 0) || (c == s.s2) || (c == s.s3);
      bus.abort = (c == s.ab);
      @(negedge clk);
      e_busy = (c >= 1) && (c <= 21) && (c <= a_eff);
      e_rd   = (c >= 1) && (c <= 16) && (c <= a_eff);
      e_en   = (c >= 1) && (c <= 20) && (c <= a_eff);
      e_wr   = (c >= 5) && (c <= 20) && (c <= a_eff);
      e_done = (c == 21) && (c <= a_eff);
      chk($sformatf("%s c%0d busy", s.name, c), int'(bus.busy), int'(e_busy));
      chk($sformatf("%s c%0d done", s.name, c), int'(bus.done), int'(e_done));
      chk($sformatf("%s c%0d col_rd_en", s.name, c), int'(bus.col_rd_en), int'(e_rd));
      chk($sformatf("%s c%0d p2_enable", s.name, c), int'(bus.p2_enable), int'(e_en));
      chk($sformatf("%s c%0d g_wr_en", s.name, c), int'(bus.g_wr_en), int'(e_wr));
      if (e_rd) chk($sformatf("%s c%0d col_addr", s.name, c), int'(bus.col_addr), c - 1);
      if (e_wr) begin
        chk($sformatf("%s c%0d g_wr_addr", s.name, c), int'(bus.g_wr_addr), c - 5);
        chk($sformatf("%s c%0d g_wr_data", s.name, c), int'(bus.g_wr_data), int'(g_of(c - 5)));
      end
`ifdef MBGD_P2_GMAX_EN
      if (c == 1 && s.ab != 0) chk($sformatf("%s g_absmax cleared", s.name), int'(bus.g_absmax), 0);
      if (e_done) chk($sformatf("%s g_absmax at done", s.name), int'(bus.g_absmax), s.gmax);
      if (c == s.ncyc - 1 && s.n_done == 1)
        chk($sformatf("%s g_absmax hold", s.name), int'(bus.g_absmax), s.gmax);
`endif
      rd += int'(bus.col_rd_en);
      wr += int'(bus.g_wr_en);
      dn += int'(bus.done);
      @(posedge clk);
      #1;
    end
    bus.start = 1'b0;
    bus.abort = 1'b0;
    chk($sformatf("%s read count", s.name), rd, s.n_rd);
    chk($sformatf("%s write count", s.name), wr, s.n_wr);
    chk($sformatf("%s done count", s.name), dn, s.n_done);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    //        name            ncyc  s2  s3  ab  gt  rd  wr  dn  gmax
    tbl[0] = '{"full",         30, -1, -1, -1, 0, 16, 16, 1, 45};
    tbl[1] = '{"start_busy",   30,  4, 21, -1, 0, 16, 16, 1, 45};
    tbl[2] = '{"abort8",       12, -1, -1,  8, 0,  8,  4, 0,  0};
    tbl[3] = '{"after_abort",  30, -1, -1, -1, 0, 16, 16, 1, 45};
    tbl[4] = '{"abort_drain",  24, -1, -1, 18, 0, 16, 14, 0,  0};
    tbl[5] = '{"start_abort",   8, -1, -1,  0, 0,  0,  0, 0,  0};
    tbl[6] = '{"gmax_seq",     30, -1, -1, -1, 1, 16, 16, 1, 127};
    tbl[7] = '{"gmax_clear",   30, -1, -1, -1, 0, 16, 16, 1, 45};

    bus.start = 1'b0;
    bus.abort = 1'b0;
    #12;
    chk("reset busy", int'(bus.busy), 0);
    chk("reset done", int'(bus.done), 0);
    chk("reset col_rd_en", int'(bus.col_rd_en), 0);
    chk("reset g_wr_en", int'(bus.g_wr_en), 0);
    resetn = 1'b1;
    @(posedge clk);
    #1;

    foreach (tbl[i]) run_scen(tbl[i]);

    // Reset in the middle of a pass while writes are in flight.
    gmode     = 1'b0;
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    repeat (6) @(posedge clk);
    #2;
    chk("pre-reset busy", int'(bus.busy), 1);
    chk("pre-reset g_wr_en", int'(bus.g_wr_en), 1);
    resetn = 1'b0;
    #1;
    chk("async rst busy", int'(bus.busy), 0);
    chk("async rst done", int'(bus.done), 0);
    chk("async rst col_rd_en", int'(bus.col_rd_en), 0);
    chk("async rst col_addr", int'(bus.col_addr), 0);
    chk("async rst p2_enable", int'(bus.p2_enable), 0);
    chk("async rst g_wr_en", int'(bus.g_wr_en), 0);
    chk("async rst g_wr_addr", int'(bus.g_wr_addr), 0);
    chk("async rst g_wr_data", int'(bus.g_wr_data), 0);
`ifdef MBGD_P2_GMAX_EN
    chk("async rst g_absmax", int'(bus.g_absmax), 0);
`endif
    repeat (2) @(posedge clk);
    #3;
    resetn = 1'b1;
    for (int c = 0; c < 25; c++) begin
      @(negedge clk);
      chk($sformatf("post-reset c%0d busy", c), int'(bus.busy), 0);
      chk($sformatf("post-reset c%0d g_wr_en", c), int'(bus.g_wr_en), 0);
      chk($sformatf("post-reset c%0d col_rd_en", c), int'(bus.col_rd_en), 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
